// File: rtl/data_mem_loader.sv
// Bus-master copy engine between a valid/ready stream and the 16-bit data memory.
// LOAD writes an input stream into consecutive words; DUMP reads consecutive words onto an output stream.
module data_mem_loader #(
  parameter int DEPTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_mem_data,
  output logic [15:0] data_mem_addr,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [15:0] data_mem_strm,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    DONE
  } state_t;

  state_t      st;
  logic [15:0] addr;
  logic [15:0] remain;

  logic [16:0] end_addr;
  logic        range_bad;
  logic        out_free;
  logic        adv;

  // The 17-bit sum catches ranges whose end would wrap past 0xFFFF.
  assign end_addr  = {1'b0, base_addr} + {1'b0, length};
  assign range_bad = end_addr > 17'(DEPTH);
  assign out_free  = !out_valid || out_ready;
  assign adv       = (st == DUMP) && (remain != 16'd0) && out_free;

  assign in_ready      = (st == LOAD);
  assign mem_write     = (st == LOAD) && in_valid;
  assign data_mem_data = (st == LOAD) ? in_data : 16'd0;
  assign data_mem_addr = addr;
  assign mem_read      = adv;
  assign busy          = (st != IDLE);
  assign done          = (st == DONE);

  // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      addr      <= 16'd0;
      remain    <= 16'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            if (range_bad) begin
              err <= 1'b1;
            end else begin
              err    <= 1'b0;
              addr   <= base_addr;
              remain <= length;
              if (length == 16'd0) st <= DONE;
              else if (mode)       st <= DUMP;
              else                 st <= LOAD;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            addr   <= addr + 16'd1;
            remain <= remain - 16'd1;
            if (remain == 16'd1) st <= DONE;
          end
        end

        DUMP: begin
          if (adv) begin
            out_data  <= data_mem_strm;
            out_valid <= 1'b1;
            addr      <= addr + 16'd1;
            remain    <= remain - 16'd1;
          end else if (out_free) begin
            // Not advancing while the sink is free means the block is exhausted.
            out_valid <= 1'b0;
            st        <= DONE;
          end
        end

        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader with a behavioural data memory (write on edge, combinational read).
// Expected values are hand-computed for each scenario.
module tb_data_mem_loader;

  localparam int DEPTH = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] length = 16'd0;
  logic [15:0] in_data = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] data_mem_data;
  logic [15:0] data_mem_addr;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] data_mem_strm;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] mem [DEPTH];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_addr = 5'd0;
  logic [15:0] tb_wdata = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .base_addr     (base_addr),
    .length        (length),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_mem_data (data_mem_data),
    .data_mem_addr (data_mem_addr),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .data_mem_strm (data_mem_strm),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Backdoor port has priority so the bench can preload words.
  always @(posedge clk) begin
    if (tb_we)
      mem[tb_addr] <= tb_wdata;
    else if (mem_write && data_mem_addr < 16'(DEPTH))
      mem[data_mem_addr[4:0]] <= data_mem_data;
  end

  assign data_mem_strm = (data_mem_addr < 16'(DEPTH)) ? mem[data_mem_addr[4:0]] : 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_addr  = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic start_xfer(input logic m, input logic [15:0] b, input logic [15:0] l);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    base_addr = b;
    length    = l;
  endtask

  // Runs a DUMP; out_ready is low on cycles stall_lo..stall_hi (cycle 0 = start cycle).
  task automatic run_dump(input logic [15:0] b, input int len, input logic [15:0] exp0,
                          input int stall_lo, input int stall_hi,
                          input int first_cyc, input int done_cyc);
    int nrecv = 0;
    bit seen_done = 1'b0;
    start_xfer(1'b1, b, 16'(len));
    for (int cyc = 1; cyc <= 20 && !seen_done; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      #1;
      if (cyc == 1) check("dp_rd_first", {31'd0, mem_read}, 32'd1);
      if (out_valid && !out_ready) begin
        check("bp_hold_data", {16'd0, out_data}, exp0 * (nrecv + 1));
        check("bp_no_read", {31'd0, mem_read}, 32'd0);
        check("bp_addr_hold", {16'd0, data_mem_addr}, b + nrecv + 1);
      end
      if (out_valid && out_ready) begin
        check("dp_data", {16'd0, out_data}, exp0 * (nrecv + 1));
        if (nrecv == 0) check("dp_first_cyc", cyc, first_cyc);
        nrecv++;
      end
      if (done) begin
        check("dp_done_cyc", cyc, done_cyc);
        seen_done = 1'b1;
      end
    end
    check("dp_done_seen", {31'd0, seen_done}, 32'd1);
    check("dp_count", nrecv, len);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check("rst_odata", {16'd0, out_data}, 32'd0);
    check("rst_addr", {16'd0, data_mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // LOAD base=3 len=4, with ignored starts mid-transfer
    start_xfer(1'b0, 16'd3, 16'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start     = (k == 1 || k == 2);
      mode      = 1'b1;
      base_addr = 16'd0;
      length    = 16'd0;
      in_valid  = 1'b1;
      in_data   = 16'hA001 + 16'(k);
      #1;
      check("ld_we", {31'd0, mem_write}, 32'd1);
      check("ld_addr", {16'd0, data_mem_addr}, 32'd3 + k);
      check("ld_wdata", {16'd0, data_mem_data}, 32'hA001 + k);
      check("ld_ready", {31'd0, in_ready}, 32'd1);
      check("ld_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ld_done", {31'd0, done}, 32'd1);
    check("ld_done_we", {31'd0, mem_write}, 32'd0);
    check("ld_done_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1;
    check("ld_done_clr", {31'd0, done}, 32'd0);
    check("ld_idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) check("ld_mem", {16'd0, mem[3 + k]}, 32'hA001 + k);

    // DUMP, with and without backpressure
    poke(5'd10, 16'h1111);
    poke(5'd11, 16'h2222);
    poke(5'd12, 16'h3333);
    run_dump(16'd10, 3, 16'h1111, 99, 99, 2, 5);
    run_dump(16'd10, 3, 16'h1111, 2, 4, 5, 8);

    // Range error: 20+5 > 24
    start_xfer(1'b0, 16'd20, 16'd5);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    #1;
    check("re_err", {31'd0, err}, 32'd1);
    check("re_busy", {31'd0, busy}, 32'd0);
    check("re_no_we", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("re_err_sticky", {31'd0, err}, 32'd1);
    check("re_busy2", {31'd0, busy}, 32'd0);

    // Zero length at the upper boundary (24+0 == DEPTH) is accepted and clears err
    start_xfer(1'b0, 16'd24, 16'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zl_done", {31'd0, done}, 32'd1);
    check("zl_err_clr", {31'd0, err}, 32'd0);
    check("zl_no_we", {31'd0, mem_write}, 32'd0);
    check("zl_no_rd", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    #1;
    check("zl_done_clr", {31'd0, done}, 32'd0);
    check("zl_idle", {31'd0, busy}, 32'd0);

    // Reset after two of four LOAD words
    for (int k = 0; k < 4; k++) poke(5'(16 + k), 16'h5555);
    start_xfer(1'b0, 16'd16, 16'd4);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'hB001 + 16'(k);
    end
    @(negedge clk);
    in_data = 16'hB003;
    #1;
    check("rs_pre_we", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rs_we", {31'd0, mem_write}, 32'd0);
    check("rs_ready", {31'd0, in_ready}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_addr", {16'd0, data_mem_addr}, 32'd0);
    check("rs_wdata", {16'd0, data_mem_data}, 32'd0);
    check("rs_rd", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rs_no_done", dn, 0);
    check("rs_mem16", {16'd0, mem[16]}, 32'hB001);
    check("rs_mem17", {16'd0, mem[17]}, 32'hB002);
    check("rs_mem18", {16'd0, mem[18]}, 32'h5555);
    check("rs_mem19", {16'd0, mem[19]}, 32'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_loader.md
# data_mem_loader

Bus-master engine for the 16-bit data memory. It copies a block of words between a streaming port and the memory's write/read strobe interface. LOAD mode writes a valid/ready input stream into consecutive memory words. DUMP mode reads consecutive words out onto a valid/ready output stream. It lets the testbench or boot logic initialise or inspect data memory without `$readmemb`, and it sits between that source/sink and the data memory's `data_mem_*` / `mem_write` / `mem_read` pins.

## Interface
- `DEPTH`, default 24: number of 16-bit words in the data memory. Used for the range check.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `mode`  in  1: 0 = LOAD (stream→memory), 1 = DUMP (memory→stream). Latched on accepted start.
- `base_addr`  in  16: first word address. Latched on accepted start.
- `length`  in  16: word count. Latched on accepted start.
- `in_data`  in  16: LOAD stream word.
- `in_valid`  in  1: LOAD stream valid.
- `in_ready`  out  1: LOAD stream ready.
- `out_data`  out  16: DUMP stream word (registered).
- `out_valid`  out  1: DUMP stream valid (registered).
- `out_ready`  in  1: DUMP stream ready.
- `data_mem_data`  out  16: write data to memory.
- `data_mem_addr`  out  16: word address to memory.
- `mem_write`  out  1: memory write enable. Memory writes on the same rising edge.
- `mem_read`  out  1: memory read enable.
- `data_mem_strm`  in  16: combinational read data from memory.
- `busy`  out  1: high in LOAD, DUMP and DONE.
- `done`  out  1: one-cycle pulse in DONE.
- `err`  out  1: sticky range-error flag.

## Operation
- State register `st` ∈ {IDLE, LOAD, DUMP, DONE}. Counters are `addr` (16b) and `remain` (16b).
- **Reset (`rst`=0, async):** `st`=IDLE, `addr`=0, `remain`=0, `out_data`=0, `out_valid`=0, `err`=0. All outputs read 0. Memory contents are not touched by this block.
- **IDLE**
  - On `start`=1, compute `base_addr`+`length` in 17 bits.
  - If the sum > `DEPTH`: set `err`=1 and stay in IDLE.
  - Else: clear `err`, load `addr`←`base_addr` and `remain`←`length`.
  - Next state: DONE if `length`=0, else LOAD (`mode`=0) or DUMP (`mode`=1).
- **LOAD**
  - `in_ready`=1.
  - `mem_write` = `in_valid`, `data_mem_data` = `in_data`, `data_mem_addr` = `addr`.
  - On each handshake: `addr`+1, `remain`−1.
  - When the handshake occurs with `remain`=1, go to DONE.
  - With `in_valid`=0 there is no write and the state holds.
- **DUMP**
  - Define `adv` = (`remain`≠0) & (!`out_valid` | `out_ready`).
  - `mem_read` = `adv`, `data_mem_addr` = `addr`.
  - When `adv`: `out_data`←`data_mem_strm`, `out_valid`←1, `addr`+1, `remain`−1.
  - When `out_valid` & `out_ready` & !`adv`: `out_valid`←0.
  - When `remain`=0 & (!`out_valid` | `out_ready`): clear `out_valid` and go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Idle output values:** outside LOAD, `mem_write`=0 and `data_mem_data`=0. Outside DUMP, `mem_read`=0. `data_mem_addr`=`addr` in all states.
- **`start` while busy:** ignored. It has no effect on `err`.
- **Address arithmetic:** wraps modulo 2^16. The range check guarantees no wrap in accepted transfers.

## Timing
- Start is sampled at edge E0. The transfer state is active from E0.
- **LOAD latency:** a word presented with `in_valid` in the cycle after E0 is written at E1.
- **LOAD throughput:** N words with continuous `in_valid` take N cycles, followed by the DONE cycle. `done` is high in cycle N+1 after E0.
- **DUMP latency:** `mem_read` is high in the cycle after E0. `out_valid`=1 with `out_data`=mem[base] from E1.
- **DUMP throughput:** with `out_ready` held high, one word per cycle, so N words take N+1 cycles before DONE.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` are stable, `mem_read`=0, and `addr` holds.
- **Async reset mid-transfer:** everything returns to IDLE immediately. `done` is not pulsed. Words already written remain in memory.

## Test plan
- **LOAD:** base=3, len=4, stream 0xA001..0xA004 with `in_valid` continuous. Required: `mem_write` for 4 cycles at addrs 3,4,5,6; a memory dump shows those values; `done` pulses once, 5 cycles after start.
- **DUMP:** preload mem[10..12]=0x1111/0x2222/0x3333, base=10, len=3, `out_ready`=1. Required: `out_data` sequence 0x1111,0x2222,0x3333 on consecutive cycles starting 1 cycle after start; then `done`.
- **DUMP backpressure:** same setup, `out_ready` low for 3 cycles after the first word. Required: `out_data` holds 0x1111 and `mem_read`=0 while stalled; no word is lost or duplicated.
- **Range error:** base=20, len=5, DEPTH=24. Required: `err`=1, `busy` stays 0, no `mem_write`. A following valid start clears `err`.
- **Zero length / start while busy:** len=0 gives a `done` pulse 1 cycle after start with no strobes. A second `start` during a LOAD is ignored, shown by an unchanged `addr` sequence.
- **Reset mid-transfer:** pull `rst` low after 2 of 4 LOAD words. Required: all outputs 0 asynchronously; mem[base..base+1] written, the rest unchanged; no `done`.
